eth_frame_serializer: RTL and testbench

- Downstream neighbour of the Ethernet packing stage, in the eth_clk domain.
- Consumes one Ethernet header (dest MAC, src MAC, type) plus its byte payload stream and emits a single flat AXI-Stream byte frame for the MAC TX path.
- Order of each output frame: 14 header bytes, then the payload, then optional zero padding up to the minimum payload length.

---
 rtl/eth_frame_serializer.sv | 148 ++++++++++++++
 tb/tb_eth_frame_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_serializer.sv
// Flattens one Ethernet header plus its payload stream into a single AXI-Stream byte frame,
// optionally zero-padding short payloads up to MIN_PAYLOAD bytes.
module eth_frame_serializer #(
    parameter bit          PAD_ENABLE  = 1'b1,
    parameter int unsigned MIN_PAYLOAD = 46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_eth_hdr_valid,
    output logic        s_eth_hdr_ready,
    input  logic [47:0] s_eth_dest_mac,
    input  logic [47:0] s_eth_src_mac,
    input  logic [15:0] s_eth_type,
    input  logic [7:0]  s_eth_payload_axis_tdata,
    input  logic        s_eth_payload_axis_tvalid,
    output logic        s_eth_payload_axis_tready,
    input  logic        s_eth_payload_axis_tlast,
    input  logic        s_eth_payload_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy
);

    localparam int unsigned HDR_W     = 112;
    localparam int unsigned HCNT_W    = 4;
    localparam int unsigned PCNT_W    = 8;
    localparam logic [HCNT_W-1:0] HDR_LAST  = HCNT_W'(13);
    localparam logic [PCNT_W:0]   MIN_P     = (PCNT_W+1)'(MIN_PAYLOAD);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} state_t;

    state_t              state, state_nxt;
    logic [HDR_W-1:0]    hdr_sr, hdr_sr_nxt;
    logic [HCNT_W-1:0]   hdr_cnt, hdr_cnt_nxt;
    logic [PCNT_W-1:0]   pay_cnt, pay_cnt_nxt, pay_cnt_sat;
    logic [PCNT_W:0]     pay_cnt_inc;
    logic                tuser_lat, tuser_lat_nxt;
    logic [7:0]          tdata_nxt;
    logic                tvalid_nxt, tlast_nxt, tuser_nxt;
    logic                load_en;

    assign load_en                   = !m_axis_tvalid || m_axis_tready;
    assign s_eth_hdr_ready           = (state == IDLE);
    assign busy                      = (state != IDLE);
    assign s_eth_payload_axis_tready = (state == PAYLOAD) && load_en;
    assign pay_cnt_inc               = {1'b0, pay_cnt} + (PCNT_W+1)'(1);
    assign pay_cnt_sat               = (pay_cnt == '1) ? pay_cnt : pay_cnt_inc[PCNT_W-1:0];

    // Next-state and next output-register contents
    always_comb begin
        state_nxt     = state;
        hdr_sr_nxt    = hdr_sr;
        hdr_cnt_nxt   = hdr_cnt;
        pay_cnt_nxt   = pay_cnt;
        tuser_lat_nxt = tuser_lat;
        tdata_nxt     = m_axis_tdata;
        tvalid_nxt    = m_axis_tvalid && !m_axis_tready;
        tlast_nxt     = m_axis_tlast;
        tuser_nxt     = m_axis_tuser;

        case (state)
            IDLE: begin
                if (s_eth_hdr_valid) begin
                    hdr_sr_nxt  = {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
                    hdr_cnt_nxt = '0;
                    pay_cnt_nxt = '0;
                    state_nxt   = HEADER;
                end
            end
            HEADER: begin
                if (load_en) begin
                    tdata_nxt   = hdr_sr[HDR_W-1 -: 8];
                    tvalid_nxt  = 1'b1;
                    tlast_nxt   = 1'b0;
                    tuser_nxt   = 1'b0;
                    hdr_sr_nxt  = {hdr_sr[HDR_W-9:0], 8'h00};
                    hdr_cnt_nxt = hdr_cnt + HCNT_W'(1);
                    if (hdr_cnt == HDR_LAST) begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (load_en && s_eth_payload_axis_tvalid) begin
                    tdata_nxt   = s_eth_payload_axis_tdata;
                    tvalid_nxt  = 1'b1;
                    tlast_nxt   = 1'b0;
                    tuser_nxt   = 1'b0;
                    pay_cnt_nxt = pay_cnt_sat;
                    if (s_eth_payload_axis_tlast) begin
                        // Short frames finish through PAD, carrying the error flag to the final pad byte
                        if (PAD_ENABLE && (pay_cnt_inc < MIN_P)) begin
                            tuser_lat_nxt = s_eth_payload_axis_tuser;
                            state_nxt     = PAD;
                        end else begin
                            tlast_nxt = 1'b1;
                            tuser_nxt = s_eth_payload_axis_tuser;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            PAD: begin
                if (load_en) begin
                    tdata_nxt   = 8'h00;
                    tvalid_nxt  = 1'b1;
                    tlast_nxt   = 1'b0;
                    tuser_nxt   = 1'b0;
                    pay_cnt_nxt = pay_cnt_sat;
                    if (pay_cnt_inc == MIN_P) begin
                        tlast_nxt = 1'b1;
                        tuser_nxt = tuser_lat;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            hdr_sr        <= '0;
            hdr_cnt       <= '0;
            pay_cnt       <= '0;
            tuser_lat     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            state         <= state_nxt;
            hdr_sr        <= hdr_sr_nxt;
            hdr_cnt       <= hdr_cnt_nxt;
            pay_cnt       <= pay_cnt_nxt;
            tuser_lat     <= tuser_lat_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tvalid <= tvalid_nxt;
            m_axis_tlast  <= tlast_nxt;
            m_axis_tuser  <= tuser_nxt;
        end
    end

endmodule

// File: tb/tb_eth_frame_serializer.sv
// Scoreboard bench for eth_frame_serializer: a padding and a non-padding instance share stimulus
// through a select, expected beats are queued at drive time and popped as the output handshakes.
module tb_eth_frame_serializer;

    localparam int LIMIT   = 4000;
    localparam int MIN_PAY = 46;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        hdr_valid;
    logic [47:0] dest, src;
    logic [15:0] etype;
    logic [7:0]  p_data;
    logic        p_valid, p_last, p_user;
    logic        m_ready;
    bit          rnd_ready;

    logic        pd_hdr_ready, pd_p_ready, pd_valid, pd_last, pd_user, pd_busy;
    logic [7:0]  pd_data;
    logic        np_hdr_ready, np_p_ready, np_valid, np_last, np_user, np_busy;
    logic [7:0]  np_data;
    logic        c_hdr_ready, c_p_ready, c_valid, c_last, c_user, c_busy;
    logic [7:0]  c_data;

    logic [9:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          beats    = 0;
    bit          mon_en   = 1'b0;
    bit          stalled  = 1'b0;
    logic [10:0] held     = '0;
    bit          gap_arm  = 1'b0;
    bit          seen_high = 1'b0;
    int          cur_low  = 0;
    int          max_gap  = 0;

    always #5 clk = ~clk;

    eth_frame_serializer #(.PAD_ENABLE(1'b1), .MIN_PAYLOAD(MIN_PAY)) u_dut_pad (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(hdr_valid & ~sel), .s_eth_hdr_ready(pd_hdr_ready),
        .s_eth_dest_mac(dest), .s_eth_src_mac(src), .s_eth_type(etype),
        .s_eth_payload_axis_tdata(p_data), .s_eth_payload_axis_tvalid(p_valid & ~sel),
        .s_eth_payload_axis_tready(pd_p_ready), .s_eth_payload_axis_tlast(p_last),
        .s_eth_payload_axis_tuser(p_user),
        .m_axis_tdata(pd_data), .m_axis_tvalid(pd_valid), .m_axis_tready(m_ready),
        .m_axis_tlast(pd_last), .m_axis_tuser(pd_user), .busy(pd_busy)
    );

    eth_frame_serializer #(.PAD_ENABLE(1'b0), .MIN_PAYLOAD(MIN_PAY)) u_dut_nopad (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(hdr_valid & sel), .s_eth_hdr_ready(np_hdr_ready),
        .s_eth_dest_mac(dest), .s_eth_src_mac(src), .s_eth_type(etype),
        .s_eth_payload_axis_tdata(p_data), .s_eth_payload_axis_tvalid(p_valid & sel),
        .s_eth_payload_axis_tready(np_p_ready), .s_eth_payload_axis_tlast(p_last),
        .s_eth_payload_axis_tuser(p_user),
        .m_axis_tdata(np_data), .m_axis_tvalid(np_valid), .m_axis_tready(m_ready),
        .m_axis_tlast(np_last), .m_axis_tuser(np_user), .busy(np_busy)
    );

    assign c_hdr_ready = sel ? np_hdr_ready : pd_hdr_ready;
    assign c_p_ready   = sel ? np_p_ready   : pd_p_ready;
    assign c_valid     = sel ? np_valid     : pd_valid;
    assign c_last      = sel ? np_last      : pd_last;
    assign c_user      = sel ? np_user      : pd_user;
    assign c_busy      = sel ? np_busy      : pd_busy;
    assign c_data      = sel ? np_data      : pd_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Output monitor: stall stability, scoreboard pop, beat count, busy-gap measurement
    always @(negedge clk) begin
        if (mon_en) begin
            if (stalled)
                check("stall_hold", 32'({c_valid, c_last, c_user, c_data}), 32'(held));
            if (c_valid && m_ready) begin
                if (exp_q.size() == 0)
                    check("extra_beat", 32'({c_valid, c_last, c_user, c_data}), 32'h0);
                else
                    check("beat", 32'({c_last, c_user, c_data}), 32'(exp_q.pop_front()));
            end
        end
        stalled = c_valid && !m_ready;
        held    = {c_valid, c_last, c_user, c_data};
        if (c_valid && m_ready) beats++;
        if (gap_arm) begin
            if (c_busy) begin
                if (seen_high && cur_low > max_gap) max_gap = cur_low;
                seen_high = 1'b1;
                cur_low   = 0;
            end else if (seen_high) begin
                cur_low++;
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic void push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                                       input int len, input logic [7:0] base, input logic user,
                                       input bit pad_en);
        logic [111:0] h;
        logic [7:0]   b;
        logic         fin;
        int           tot;
        h   = {d, s, t};
        tot = (pad_en && len < MIN_PAY) ? MIN_PAY : len;
        for (int i = 0; i < 14; i++) exp_q.push_back({2'b00, h[111-8*i -: 8]});
        for (int j = 0; j < tot; j++) begin
            b   = (j < len) ? base + 8'(j) : 8'h00;
            fin = (j == tot - 1);
            exp_q.push_back({fin, fin & user, b});
        end
    endfunction

    task automatic hdr_handshake(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        int n;
        bit ok;
        dest = d; src = s; etype = t; hdr_valid = 1'b1; n = 0;
        do begin
            @(negedge clk); ok = c_hdr_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < LIMIT);
        hdr_valid = 1'b0;
        if (!ok) begin
            check("hdr_accept", 32'(c_hdr_ready), 32'h1);
            finish_run();
        end
    endtask

    task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int len, input logic [7:0] base, input logic user, input bit rnd_valid);
        int n;
        bit ok;
        push_frame(d, s, t, len, base, user, !sel);
        hdr_handshake(d, s, t);
        for (int i = 0; i < len; i++) begin
            if (rnd_valid) begin
                while ($urandom_range(0, 2) == 0) begin
                    p_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            p_valid = 1'b1;
            p_data  = base + 8'(i);
            p_last  = (i == len - 1);
            p_user  = p_last ? user : 1'($urandom_range(0, 1));
            n = 0;
            do begin
                @(negedge clk); ok = c_p_ready;
                @(posedge clk); #1; n++;
            end while (!ok && n < LIMIT);
            if (!ok) begin
                check("pay_accept", 32'(c_p_ready), 32'h1);
                finish_run();
            end
        end
        p_valid = 1'b0; p_last = 1'b0; p_user = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < LIMIT) begin
            @(posedge clk); #1; n++;
        end
        check(tag, 32'(exp_q.size()), 32'h0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        int b0, n;
        rst = 1'b1; sel = 1'b0; hdr_valid = 1'b0; rnd_ready = 1'b0;
        dest = '0; src = '0; etype = '0; p_data = '0; p_valid = 1'b0; p_last = 1'b0; p_user = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(c_valid), 32'h0);
        check("rst_tdata", 32'(c_data), 32'h0);
        check("rst_hdr_ready", 32'(c_hdr_ready), 32'h1);
        check("rst_busy", 32'(c_busy), 32'h0);
        check("rst_pay_ready", 32'(c_p_ready), 32'h0);
        rst = 1'b0; mon_en = 1'b1;

        // 60-byte frame, no padding needed
        send_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 60, 8'h00, 1'b0, 1'b0);
        drain("drain_60");
        // 10-byte frame padded to 46 with error flag on the final pad byte
        send_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 10, 8'hA0, 1'b1, 1'b0);
        drain("drain_pad");
        // Same frame through the non-padding instance
        sel = 1'b1;
        send_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 10, 8'hA0, 1'b1, 1'b0);
        drain("drain_nopad");
        sel = 1'b0;

        // Back-to-back 46-byte frames: busy may drop for one cycle only
        gap_arm = 1'b1;
        send_frame(48'h020000000001, 48'h020000000002, 16'h86DD, 46, 8'h10, 1'b0, 1'b0);
        send_frame(48'h020000000003, 48'h020000000004, 16'h0806, 46, 8'h50, 1'b0, 1'b0);
        drain("drain_b2b");
        gap_arm = 1'b0;
        check("b2b_gap", 32'(max_gap), 32'h1);

        // Random backpressure and payload gaps
        rnd_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            send_frame({16'h0000, 32'($urandom)}, {$urandom, 16'h0000}, 16'($urandom),
                       int'($urandom_range(1, 100)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain("drain_rand");
        rnd_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Reset while header byte 5 is on the bus
        mon_en = 1'b0;
        b0 = beats;
        hdr_handshake(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0800);
        n = 0;
        while (beats != b0 + 5 && n < LIMIT) begin
            @(posedge clk); #1; n++;
        end
        check("rst_mid_reach", 32'(beats - b0), 32'h5);
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", 32'(c_valid), 32'h0);
        check("mid_rst_hdr_ready", 32'(c_hdr_ready), 32'h1);
        check("mid_rst_busy", 32'(c_busy), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        rnd_ready = 1'b1;
        send_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 20, 8'h30, 1'b0, 1'b1);
        drain("drain_post_rst");
        rnd_ready = 1'b0;

        finish_run();
    end

endmodule
